// File: rtl/div_unit.sv
// Iterative restoring divider: one quotient bit per clock, start/done handshake.
// Signed mode present only with DIV_SIGNED_EN; otherwise all operations are unsigned.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, signed_op       request and mode, sampled when not busy
//   dividend, divisor      operands, sampled with start
//   busy, done             in-progress flag, one-cycle completion pulse
//   quotient, remainder    registered results, held until next result
//   div_by_zero            registered divide-by-zero flag
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend magnitude, shifts into quotient
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] raw_q, raw_d;   // untouched dividend for divide-by-zero
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             dzo_q, dzo_d;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] q_fix, r_fix;
    logic             sa, sb;

`ifdef DIV_SIGNED_EN
    assign sa    = signed_op & dividend[WIDTH-1];
    assign sb    = signed_op & divisor[WIDTH-1];
    assign mag_a = sa ? -dividend : dividend;
    assign mag_b = sb ? -divisor : divisor;
    assign q_fix = qneg_q ? -dvd_q : dvd_q;
    assign r_fix = rneg_q ? -rem_q : rem_q;
`else
    logic unused_sign;
    assign unused_sign = signed_op ^ qneg_q ^ rneg_q;
    assign sa    = 1'b0;
    assign sb    = 1'b0;
    assign mag_a = dividend;
    assign mag_b = divisor;
    assign q_fix = dvd_q;
    assign r_fix = rem_q;
`endif

    // Borrow out of the WIDTH+1 bit subtract means rem < |divisor|.
    assign rem_sh = {rem_q, dvd_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            raw_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
            quot_q <= '0;
            remo_q <= '0;
            dzo_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            dvd_q  <= dvd_d;
            dvs_q  <= dvs_d;
            raw_q  <= raw_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            dz_q   <= dz_d;
            quot_q <= quot_d;
            remo_q <= remo_d;
            dzo_q  <= dzo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        raw_d   = raw_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dzo_d   = dzo_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                done = (state_q == DONE);
                if (start) begin
                    raw_d   = dividend;
                    dvd_d   = mag_a;
                    dvs_d   = mag_b;
                    qneg_d  = sa ^ sb;
                    rneg_d  = sa;
                    rem_d   = '0;
                    cnt_d   = CW'(WIDTH - 1);
                    dz_d    = (divisor == '0);
                    state_d = (divisor == '0) ? FIX : RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (!diff[WIDTH]) begin
                    rem_d = diff[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                busy    = 1'b1;
                quot_d  = dz_q ? '1 : q_fix;
                remo_d  = dz_q ? raw_q : r_fix;
                dzo_d   = dz_q;
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign quotient    = quot_q;
    assign remainder   = remo_q;
    assign div_by_zero = dzo_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard testbench for div_unit: directed cases plus randomized operands.
// Expected results come from plain integer arithmetic on the operands.
module tb_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         signed_op = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           tdone;
    } exp_t;

    exp_t sbq[$];
    exp_t me;

    div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic s);
        exp_t e;
        int sa;
        int sbv;
        logic unused_s;
        unused_s = s;
        e.q = '0;
        e.r = '0;
        e.dz = 1'b0;
        e.tdone = 0;
        sa = a;
        sbv = b;
        if (b == 0) begin
            e.q = '1;
            e.r = a;
            e.dz = 1'b1;
        end
`ifdef DIV_SIGNED_EN
        else if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.q = 32'h8000_0000;
                e.r = '0;
            end else begin
                e.q = sa / sbv;
                e.r = sa % sbv;
            end
        end
`endif
        else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
                me = sbq.pop_front();
                check("quotient", 64'(quotient), 64'(me.q));
                check("remainder", 64'(remainder), 64'(me.r));
                check("div_by_zero", 64'(div_by_zero), 64'(me.dz));
                check("latency", 64'(cyc), 64'(me.tdone));
                check("busy_in_done", 64'(busy), 64'd0);
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s);
        exp_t e2;
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL issue_timeout: busy 1 expected 0");
            return;
        end
        dividend = a;
        divisor = b;
        signed_op = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        e2 = model(a, b, s);
        e2.tdone = cyc + ((b == 0) ? 1 : W + 1);
        sbq.push_back(e2);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: pending %0d expected 0", sbq.size());
            sbq.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL wait_done_timeout: done 0 expected 1");
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_quotient"}, 64'(quotient), 64'd0);
        check({tag, "_remainder"}, 64'(remainder), 64'd0);
        check({tag, "_dz"}, 64'(div_by_zero), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        issue(32'd100, 32'd7, 1'b0);
        wait_idle();
        issue(32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_idle();
        issue(32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_idle();
        issue(32'd5, 32'd0, 1'b0);
        wait_idle();
        issue(32'd5, 32'd0, 1'b1);
        wait_idle();

        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done();
        issue(32'd9, 32'd3, 1'b1);
        wait_idle();

        issue(32'd100, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        dividend = 32'd50;
        divisor = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        issue(32'd100, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        sbq.delete();
        #1;
        check_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(32'd20, 32'd6, 1'b0);
        wait_idle();

        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: b = $urandom_range(1, 15);
                1: b = '0;
                2: b = 32'hFFFF_FFFF - $urandom_range(0, 14);
                3: begin
                    a = $urandom_range(0, 1000);
                    b = $urandom_range(1, 50);
                end
                4: begin
                    a = 32'h8000_0000;
                    if ($urandom_range(0, 1) == 1) b = '1;
                end
                default: ;
            endcase
            issue(a, b, s);
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
